// File: rtl/std_gate_unit_if.sv
// Bus bundle for std_gate_unit: operands, select and in_valid in; combinational and registered results out.
// Buses run [0:WIDTH-1] with bit 0 as the MSB.
interface std_gate_unit_if #(
  parameter int WIDTH = 32
);
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic             sel;
  logic             in_valid;
  logic [0:WIDTH-1] and_out;
  logic [0:WIDTH-1] not_out;
  logic [0:WIDTH-1] mux_out;
  logic [0:WIDTH-1] and_q;
  logic [0:WIDTH-1] not_q;
  logic [0:WIDTH-1] mux_q;
  logic             out_valid;

  modport master (
    output a, b, sel, in_valid,
    input  and_out, not_out, mux_out, and_q, not_q, mux_q, out_valid
  );

  modport slave (
    input  a, b, sel, in_valid,
    output and_out, not_out, mux_out, and_q, not_q, mux_q, out_valid
  );
endinterface

// File: rtl/std_gate_unit.sv
// Per-bit AND2/NOT/MUX2 gate library with zero-latency outputs plus a 1-cycle registered copy.
// No backpressure: every in_valid beat is captured and out_valid pulses for one cycle.
module std_gate_and2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

module std_gate_not (
  input  logic a_i,
  output logic y_o
);
  assign y_o = ~a_i;
endmodule

module std_gate_mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);
  // Ternary keeps X on sel visible except where both data inputs agree.
  assign y_o = sel_i ? b_i : a_i;
endmodule

module std_gate_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  std_gate_unit_if.slave bus
);
  logic [0:WIDTH-1] and_d;
  logic [0:WIDTH-1] not_d;
  logic [0:WIDTH-1] mux_d;
  logic [0:WIDTH-1] and_nxt_d;
  logic [0:WIDTH-1] not_nxt_d;
  logic [0:WIDTH-1] mux_nxt_d;
  logic             out_valid_d;
  logic [0:WIDTH-1] and_q;
  logic [0:WIDTH-1] not_q;
  logic [0:WIDTH-1] mux_q;
  logic             out_valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    std_gate_and2 u_and (
      .a_i (bus.a[i]),
      .b_i (bus.b[i]),
      .y_o (and_d[i])
    );
    std_gate_not u_not (
      .a_i (bus.a[i]),
      .y_o (not_d[i])
    );
    std_gate_mux2 u_mux (
      .a_i   (bus.a[i]),
      .b_i   (bus.b[i]),
      .sel_i (bus.sel),
      .y_o   (mux_d[i])
    );
  end

  always_comb begin
    and_nxt_d   = and_q;
    not_nxt_d   = not_q;
    mux_nxt_d   = mux_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      and_nxt_d   = and_d;
      not_nxt_d   = not_d;
      mux_nxt_d   = mux_d;
      out_valid_d = 1'b1;
    end
  end

  // Reset outranks in_valid so an in-flight beat is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      and_q       <= '0;
      not_q       <= '0;
      mux_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      and_q       <= and_nxt_d;
      not_q       <= not_nxt_d;
      mux_q       <= mux_nxt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.and_out   = and_d;
  assign bus.not_out   = not_d;
  assign bus.mux_out   = mux_d;
  assign bus.and_q     = and_q;
  assign bus.not_q     = not_q;
  assign bus.mux_q     = mux_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_std_gate_unit.sv
// Directed bench for std_gate_unit at WIDTH=32 and WIDTH=5.
module tb_std_gate_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  std_gate_unit_if #(.WIDTH(32)) ifc32 ();
  std_gate_unit_if #(.WIDTH(5))  ifc5 ();

  std_gate_unit #(.WIDTH(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc32.slave)
  );

  std_gate_unit #(.WIDTH(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc5.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs32(input string tag, input logic [31:0] e_and, input logic [31:0] e_not,
                              input logic [31:0] e_mux, input logic e_vld);
    check({tag, ".and_q"}, ifc32.and_q, e_and);
    check({tag, ".not_q"}, ifc32.not_q, e_not);
    check({tag, ".mux_q"}, ifc32.mux_q, e_mux);
    check({tag, ".out_valid"}, {31'b0, ifc32.out_valid}, {31'b0, e_vld});
  endtask

  initial begin
    rst_n          = 1'b0;
    ifc32.a        = 32'h0;
    ifc32.b        = 32'h0;
    ifc32.sel      = 1'b0;
    ifc32.in_valid = 1'b0;
    ifc5.a         = 5'b0;
    ifc5.b         = 5'b0;
    ifc5.sel       = 1'b0;
    ifc5.in_valid  = 1'b0;

    // Hold reset for two edges.
    @(posedge clk); @(posedge clk); #1;
    check_regs32("rst32", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst5.and_q", {27'b0, ifc5.and_q}, 32'h0);
    check("rst5.out_valid", {31'b0, ifc5.out_valid}, 32'h0);

    // Combinational checks, still under reset.
    ifc32.a = 32'h00000011; ifc32.b = 32'h00000000; ifc32.sel = 1'b0; #1;
    check("c32a.and", ifc32.and_out, 32'h00000000);
    check("c32a.not", ifc32.not_out, 32'hFFFFFFEE);
    check("c32a.mux", ifc32.mux_out, 32'h00000011);
    ifc32.sel = 1'b1; #1;
    check("c32b.mux", ifc32.mux_out, 32'h00000000);
    ifc32.a = 32'hFFFFFFFF; ifc32.b = 32'hFFFFFFFF; #1;
    check("c32c.and", ifc32.and_out, 32'hFFFFFFFF);
    check("c32c.not", ifc32.not_out, 32'h00000000);

    ifc5.a = 5'b11111; ifc5.b = 5'b11111; ifc5.sel = 1'b0; #1;
    check("c5a.and", {27'b0, ifc5.and_out}, 32'h1F);
    check("c5a.not", {27'b0, ifc5.not_out}, 32'h00);
    check("c5a.mux0", {27'b0, ifc5.mux_out}, 32'h1F);
    ifc5.sel = 1'b1; #1;
    check("c5a.mux1", {27'b0, ifc5.mux_out}, 32'h1F);
    ifc5.a = 5'b10101; ifc5.b = 5'b01010; #1;
    check("c5b.and", {27'b0, ifc5.and_out}, 32'h00);
    check("c5b.not", {27'b0, ifc5.not_out}, 32'h0A);
    check("c5b.mux", {27'b0, ifc5.mux_out}, 32'h0A);
    ifc5.sel = 1'b0; #1;
    check("c5c.mux", {27'b0, ifc5.mux_out}, 32'h15);

    // Bit order: a[0] is the MSB.
    ifc32.a = 32'h80000000; ifc32.b = 32'h0; ifc32.sel = 1'b0; #1;
    check("bo.not", ifc32.not_out, 32'h7FFFFFFF);
    check("bo.not0", {31'b0, ifc32.not_out[0]}, 32'h0);
    check("bo.a0", {31'b0, ifc32.mux_out[0]}, 32'h1);

    // Registered path.
    @(negedge clk);
    rst_n = 1'b1;
    ifc32.a = 32'h0000FFFF; ifc32.b = 32'h00FF00FF; ifc32.sel = 1'b1; ifc32.in_valid = 1'b1;
    @(posedge clk); #1;
    check_regs32("reg1", 32'h000000FF, 32'hFFFF0000, 32'h00FF00FF, 1'b1);

    @(negedge clk);
    ifc32.in_valid = 1'b0; ifc32.a = 32'h12345678; ifc32.b = 32'h0; ifc32.sel = 1'b0;
    @(posedge clk); #1;
    check_regs32("hold", 32'h000000FF, 32'hFFFF0000, 32'h00FF00FF, 1'b0);

    // Back-to-back valid beats.
    @(negedge clk);
    ifc32.in_valid = 1'b1; ifc32.a = 32'h12345678; ifc32.b = 32'hF0F0F0F0; ifc32.sel = 1'b0;
    @(posedge clk); #1;
    check_regs32("b2b1", 32'h10305070, 32'hEDCBA987, 32'h12345678, 1'b1);
    @(negedge clk);
    ifc32.a = 32'hAAAAAAAA; ifc32.b = 32'h0F0F0F0F; ifc32.sel = 1'b1;
    @(posedge clk); #1;
    check_regs32("b2b2", 32'h0A0A0A0A, 32'h55555555, 32'h0F0F0F0F, 1'b1);

    // Reset beats a simultaneous valid beat.
    @(negedge clk);
    rst_n = 1'b0; ifc32.a = 32'hDEADBEEF; ifc32.b = 32'hFFFF0000; ifc32.sel = 1'b1;
    @(posedge clk); #1;
    check_regs32("rstpri", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rstpri.and_out", ifc32.and_out, 32'hDEAD0000);
    check("rstpri.not_out", ifc32.not_out, 32'h21524110);
    check("rstpri.mux_out", ifc32.mux_out, 32'hFFFF0000);

    @(negedge clk);
    ifc32.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post.out_valid", {31'b0, ifc32.out_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/std_gate_unit.md
# std_gate_unit

Parameterized N-bit gate-library unit that provides bitwise two-input AND, bitwise NOT and a two-way multiplexer, built from per-bit primitive gates. It also provides a one-stage registered copy of every result. It sits in the processor's standard gate library as the generic building block for datapath logic such as operand masking, inversion and source selection. Combinational outputs serve same-cycle consumers. Registered outputs serve pipelined consumers.

## Interface

Parameters:
- WIDTH, default 32: bus width in bits; must be ≥ 1. The library is instantiated at 32 and 5.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- a  input  [0:WIDTH-1]  operand A; bit 0 is the MSB.
- b  input  [0:WIDTH-1]  operand B; bit 0 is the MSB.
- sel  input  1  mux select: 0 selects a, 1 selects b.
- in_valid  input  1  qualifies a, b and sel for the registered stage.
- and_out  output  [0:WIDTH-1]  combinational a & b.
- not_out  output  [0:WIDTH-1]  combinational ~a.
- mux_out  output  [0:WIDTH-1]  combinational value: a when sel=0, otherwise b.
- and_q  output  [0:WIDTH-1]  registered and_out.
- not_q  output  [0:WIDTH-1]  registered not_out.
- mux_q  output  [0:WIDTH-1]  registered mux_out.
- out_valid  output  1  the registered outputs hold a result captured from a valid input.

## Operation

- Combinational path:
  - Each bit i of and_out, not_out and mux_out is computed by its own 1-bit primitive (AND2, NOT, MUX2).
  - The primitives are replicated WIDTH times with a generate loop.
  - Per bit: and_out[i] = a[i] & b[i]; not_out[i] = ~a[i]; mux_out[i] = sel ? b[i] : a[i].
- Bit ordering:
  - Buses are declared [0:WIDTH-1], with bit 0 as the MSB.
  - Hex values in this document read MSB-first.
- Registered path, on each rising edge of clk:
  - If rst_n=0: and_q, not_q and mux_q are cleared to all-zeros and out_valid is cleared to 0.
  - Else if in_valid=1: and_q, not_q and mux_q load and_out, not_out and mux_out; out_valid is set to 1.
  - Else (in_valid=0): and_q, not_q and mux_q hold their values; out_valid is cleared to 0.
- X handling: the unit does not sanitize inputs. If sel is X, mux_out bits propagate X except where a[i] equals b[i].
- The unit contains no other state and no handshake beyond in_valid and out_valid. There is no backpressure; out_valid is a one-cycle pulse per accepted input.

## Timing

- Combinational outputs:
  - Zero-cycle latency; they are unaffected by clk and rst_n.
  - They reflect the inputs within the same cycle, including while reset is asserted.
- Registered outputs:
  - Latency is 1 cycle: inputs sampled at edge k appear on the *_q outputs and on out_valid after edge k.
  - Back-to-back valid inputs give back-to-back valid outputs.
- Reset:
  - Synchronous and active-low; it takes effect only at a clock edge.
  - Reset has priority over in_valid.
  - Asserting reset mid-stream discards the in-flight value. *_q are all-zeros and out_valid=0 after the edge.
- Reset values: and_q, not_q and mux_q are all-zeros; out_valid is 0.
- Before the first reset edge, register contents are unspecified.

## Test plan

- WIDTH=32: a=32'h00000011, b=32'h00000000, sel=0 -> and_out=00000000, not_out=FFFFFFEE, mux_out=00000011.
- WIDTH=32: same a and b, sel=1 -> mux_out=00000000. Then a=b=FFFFFFFF -> and_out=FFFFFFFF, not_out=00000000.
- WIDTH=5: a=5'b11111, b=5'b11111 -> and_out=1F, not_out=00, mux_out=1F for both sel values. Then a=10101, b=01010, sel=1 -> and_out=00, not_out=01010, mux_out=01010.
- Registered path:
  - Setup: hold rst_n=0 for 2 edges (*_q=0, out_valid=0), then release.
  - Apply in_valid=1 with a=0000FFFF, b=00FF00FF, sel=1. After one edge: and_q=000000FF, not_q=FFFF0000, mux_q=00FF00FF, out_valid=1.
  - Next edge with in_valid=0 -> values held, out_valid=0.
- Reset priority: set rst_n=0 and in_valid=1 on the same edge -> *_q=0 and out_valid=0. Combinational outputs still track the inputs.
- Bit order: a=32'h80000000 (a[0]=1), b=0 -> not_out=7FFFFFFF and not_out[0]=0.
